// File: rtl/reset_sequencer.sv
// Reset sequencer: holds NUM_CH reset outputs after power-on or a reset request.
// It then releases them one at a time in order, lowest channel first.
// Ports: clk; reset_n (sync, active-low); ext_req_n (async button, active-low);
//        sw_req (sync software request); rst_out[NUM_CH] (active-high);
//        busy; cause (0 = reset_n, 1 = external, 2 = software).
module reset_sequencer #(
  parameter int NUM_CH       = 3,
  parameter int TIMER_BIT    = 24,
  parameter int STAGGER_BIT  = 8,
  parameter int DEBOUNCE_BIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ext_req_n,
  input  logic              sw_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic [1:0]        cause
);

  localparam int CW = ((TIMER_BIT > STAGGER_BIT) ? TIMER_BIT : STAGGER_BIT) + 1;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = DEBOUNCE_BIT + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'((1 << TIMER_BIT) - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((1 << STAGGER_BIT) - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(1 << DEBOUNCE_BIT);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_EXT = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [IW-1:0]     idx_q,     idx_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              busy_q,    busy_d;
  logic [1:0]        cause_q,   cause_d;
  logic              sync1_q,   sync1_d;
  logic              sync2_q,   sync2_d;
  logic [DW-1:0]     deb_q,     deb_d;
  logic              sw_q,      sw_d;

  logic ext_evt;
  logic ext_held;
  logic sw_evt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    cause_d   = cause_q;
    sync1_d   = ext_req_n;
    sync2_d   = sync1_q;
    sw_d      = sw_req;
    deb_d     = deb_q;

    // Debounce counts consecutive low samples and parks at DEB_MAX so a held
    // button fires only once; any high sample clears it.
    if (sync2_q) begin
      deb_d = '0;
    end else if (deb_q != DEB_MAX) begin
      deb_d = deb_q + DW'(1);
    end

    ext_evt  = !sync2_q && (deb_q == DEB_MAX - DW'(1));
    ext_held = (deb_q == DEB_MAX);
    sw_evt   = sw_req && !sw_q;

    if (ext_evt || sw_evt) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      cause_d   = ext_evt ? CAUSE_EXT : CAUSE_SW;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (ext_held) begin
            // Button still held: keep the hold timer parked at zero.
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IW'(1);
            for (int i = 0; i < NUM_CH; i++) begin
              if (i == int'(idx_q)) rst_out_d[i] = 1'b0;
            end
            if (idx_q == IDX_LAST) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
        end
      endcase
    end

    busy_d = |rst_out_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      cause_q   <= CAUSE_POR;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= '0;
      sw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      sw_q      <= sw_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ext_req_n = 1'b1;
  logic       sw_req = 1'b0;
  logic [2:0] rst_out;
  logic       busy;
  logic [1:0] cause;
  logic [0:0] rst_out1;
  logic       busy1;
  logic [1:0] cause1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(3), .TIMER_BIT(4), .STAGGER_BIT(2), .DEBOUNCE_BIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .ext_req_n(ext_req_n), .sw_req(sw_req),
    .rst_out(rst_out), .busy(busy), .cause(cause)
  );

  // Single-channel instance shares all inputs; its only channel follows channel 0.
  reset_sequencer #(.NUM_CH(1), .TIMER_BIT(4), .STAGGER_BIT(2), .DEBOUNCE_BIT(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .ext_req_n(ext_req_n), .sw_req(sw_req),
    .rst_out(rst_out1), .busy(busy1), .cause(cause1)
  );

  typedef struct {
    int         adv;
    logic       rn;
    logic       en;
    logic       sw;
    logic [2:0] exp_rst;
    logic       exp_busy;
    logic [1:0] exp_cause;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input int adv, input logic rn, input logic en, input logic sw,
                   input logic [2:0] r, input logic b, input logic [1:0] c);
    vec_t t;
    t.adv = adv; t.rn = rn; t.en = en; t.sw = sw;
    t.exp_rst = r; t.exp_busy = b; t.exp_cause = c;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt;
    // power-on: reset_n low 2 edges, then 20/24/28 release
    v( 2, 0, 1, 0, 3'b111, 1, 0);
    v(19, 1, 1, 0, 3'b111, 1, 0);
    v( 1, 1, 1, 0, 3'b110, 1, 0);
    v( 3, 1, 1, 0, 3'b110, 1, 0);
    v( 1, 1, 1, 0, 3'b100, 1, 0);
    v( 3, 1, 1, 0, 3'b100, 1, 0);
    v( 1, 1, 1, 0, 3'b000, 0, 0);
    v( 5, 1, 1, 0, 3'b000, 0, 0);
    // single-cycle software request from RUN
    v( 1, 1, 1, 1, 3'b111, 1, 2);
    v(19, 1, 1, 0, 3'b111, 1, 2);
    v( 1, 1, 1, 0, 3'b110, 1, 2);
    v( 4, 1, 1, 0, 3'b100, 1, 2);
    v( 4, 1, 1, 0, 3'b000, 0, 2);
    // sw_req held high: a single event only
    v( 1, 1, 1, 1, 3'b111, 1, 2);
    v(19, 1, 1, 1, 3'b111, 1, 2);
    v( 1, 1, 1, 1, 3'b110, 1, 2);
    v( 8, 1, 1, 0, 3'b000, 0, 2);
    // short button press: below debounce length
    v( 5, 1, 0, 0, 3'b000, 0, 2);
    v( 8, 1, 1, 0, 3'b000, 0, 2);
    // software request on the edge channel 0 would fall
    v( 1, 1, 1, 1, 3'b111, 1, 2);
    v(19, 1, 1, 0, 3'b111, 1, 2);
    v( 1, 1, 1, 1, 3'b111, 1, 2);
    v(19, 1, 1, 0, 3'b111, 1, 2);
    v( 1, 1, 1, 0, 3'b110, 1, 2);
    v( 4, 1, 1, 0, 3'b100, 1, 2);
    // reset_n for one edge mid-release, with a coincident sw request
    v( 1, 0, 1, 1, 3'b111, 1, 0);
    v(19, 1, 1, 0, 3'b111, 1, 0);
    v( 1, 1, 1, 0, 3'b110, 1, 0);
    v( 4, 1, 1, 0, 3'b100, 1, 0);
    v( 4, 1, 1, 0, 3'b000, 0, 0);
    // 12-cycle button press: event after 2 sync + 8 debounce edges
    v( 9, 1, 0, 0, 3'b000, 0, 0);
    v( 1, 1, 0, 0, 3'b111, 1, 1);
    v( 2, 1, 0, 0, 3'b111, 1, 1);
    // released: 2 sync + 1 clear edge, then 20/24/28
    v(22, 1, 1, 0, 3'b111, 1, 1);
    v( 1, 1, 1, 0, 3'b110, 1, 1);
    v( 4, 1, 1, 0, 3'b100, 1, 1);
    v( 4, 1, 1, 0, 3'b000, 0, 1);

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset_n   = tbl[i].rn;
      ext_req_n = tbl[i].en;
      sw_req    = tbl[i].sw;
      tick(tbl[i].adv);
      check("rst_out", i, {5'd0, rst_out}, {5'd0, tbl[i].exp_rst});
      check("busy",    i, {7'd0, busy},    {7'd0, tbl[i].exp_busy});
      check("cause",   i, {6'd0, cause},   {6'd0, tbl[i].exp_cause});
      check("rst_out1", i, {7'd0, rst_out1}, {7'd0, tbl[i].exp_rst[0]});
      check("busy1",    i, {7'd0, busy1},    {7'd0, tbl[i].exp_rst[0]});
    end

    // coincident external and software events: external wins
    sw_req = 1'b1; tick(1);
    sw_req = 1'b0;
    check("pre_cause", 100, {6'd0, cause}, 8'd2);
    ext_req_n = 1'b0; tick(9);
    sw_req = 1'b1; tick(1);
    sw_req = 1'b0;
    check("coinc_cause", 101, {6'd0, cause}, 8'd1);
    check("coinc_rst", 102, {5'd0, rst_out}, 8'b111);
    // button held long past the hold time: nothing releases
    tick(30);
    check("held_rst", 103, {5'd0, rst_out}, 8'b111);
    check("held_busy", 104, {7'd0, busy}, 8'd1);
    ext_req_n = 1'b1;
    cnt = 0;
    while (rst_out !== 3'b000 && cnt < 100) begin
      tick(1);
      cnt++;
    end
    check("release_edges", 105, 8'(cnt), 8'd31);
    check("release_busy", 106, {7'd0, busy}, 8'd0);
    check("release_cause", 107, {6'd0, cause}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent reset output channels, 1..16.
REQ-002 Parameter TIMER_BIT, default 24: power-on hold length HOLD_CYC = 2^TIMER_BIT cycles.
REQ-003 Parameter STAGGER_BIT, default 8: gap between channel releases GAP = 2^STAGGER_BIT cycles.
REQ-004 Parameter DEBOUNCE_BIT, default 16: external request debounce length DEB_CYC = 2^DEBOUNCE_BIT cycles.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 ext_req_n  input  1  asynchronous active-low reset request from a board button.
REQ-008 sw_req  input  1  synchronous single-cycle software reset request.
REQ-009 rst_out  output  NUM_CH  active-high reset per channel; channel 0 is released first.
REQ-010 busy  output  1  high while any rst_out bit is high.
REQ-011 cause  output  2  last reset source: 0 = reset_n, 1 = external, 2 = software; 3 is never produced.

Function
REQ-012 States SHALL be HOLD, RELEASE and RUN; state, hold/gap counter (width max(TIMER_BIT,STAGGER_BIT)+1) and channel index SHALL be registers.
REQ-013 HOLD: counter increments each edge; at the edge where counter == HOLD_CYC-1 -> RELEASE, counter <= 0, index <= 0.
REQ-014 RELEASE: counter increments each edge; at the edge where counter == GAP-1 -> rst_out[index] <= 0, counter <= 0, index <= index+1.
REQ-015 When the channel released is NUM_CH-1, the same edge SHALL move to RUN; busy SHALL fall on that edge.
REQ-016 Channel k SHALL therefore fall exactly HOLD_CYC + (k+1)*GAP edges after the first edge with reset_n high; no channel SHALL fall before a lower-numbered channel.
REQ-017 RUN: all rst_out low, counter held at 0; state changes only on a request.
REQ-018 ext_req_n SHALL pass a 2-flop synchroniser; a debounce counter increments while the synchronised level is low, clears when high, and saturates at DEB_CYC.
REQ-019 An external event SHALL fire once, on the edge where the debounce counter reaches DEB_CYC; a further event requires release (high) then a new full debounce.
REQ-020 While the debounce counter is saturated (button held), the sequencer SHALL stay in HOLD with counter 0.
REQ-021 An event (external or sw_req) in any state SHALL on the same edge set all rst_out to 1, busy to 1, counter and index to 0, state to HOLD, and cause to the source.
REQ-022 External and software events on the same edge: cause SHALL be 1 (external wins).
REQ-023 sw_req held high for several cycles SHALL be treated as one event per rising edge of sw_req (edge-detected internally).
REQ-024 Events during HOLD or RELEASE SHALL restart the full sequence; already-released channels SHALL re-assert.

Reset
REQ-025 While reset_n is low at an edge: state HOLD, counter 0, index 0, rst_out all 1s, busy 1, cause 0, debounce counter 0, synchroniser flops 1, sw_req edge detector 0.
REQ-026 reset_n low mid-RELEASE or mid-RUN SHALL take effect at the next edge, overriding any simultaneous event; cause SHALL read 0.
REQ-027 No output SHALL be X after the first edge with reset_n low.

Verification (NUM_CH=3, TIMER_BIT=4, STAGGER_BIT=2, DEBOUNCE_BIT=3 unless noted)
REQ-028 reset_n low 2 edges then high -> rst_out = 3'b111 through edge 19; 3'b110 after edge 20; 3'b100 after edge 24; 3'b000 and busy 0 after edge 28; cause 0.
REQ-029 In RUN, sw_req pulsed 1 cycle -> next edge rst_out 3'b111, busy 1, cause 2; channels release again 20/24/28 edges later.
REQ-030 In RUN, ext_req_n low for 5 cycles then high -> no event (debounce not reached), rst_out stays 0; low for 12 cycles -> exactly one event, cause 1, sequence held in HOLD until ext_req_n returns high, then 16+4/8/12 edges to release.
REQ-031 sw_req asserted at the edge where rst_out[0] would fall (edge 20) -> rst_out stays 3'b111, counter restarts, cause 2; ext and sw event coincident -> cause 1.
REQ-032 reset_n pulled low for 1 edge while in RELEASE with rst_out = 3'b100 -> rst_out 3'b111, cause 0, full 20/24/28 sequence repeats; NUM_CH=1 run -> single bit falls after edge 20, busy falls same edge.
